// File: rtl/alu_arbiter.sv
// Two-port arbiter that shares one combinational ALU between the EX stage (port 0)
// and the multi-cycle helper (port 1). Define ALU_ARB_RR_EN for round-robin grants.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_f0,
  input  logic [3:0]       req_f1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [4:0]       req_shamt0,
  input  logic [4:0]       req_shamt1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_f,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic [3:0]       f_q, f_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       shamt_q, shamt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_sel;

  function automatic logic is_legal(input logic [3:0] f);
    case (f)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'hA, 4'hB: is_legal = 1'b1;
      default:                                  is_legal = 1'b0;
    endcase
  endfunction

  // Index of the requester that wins if the arbiter accepts this cycle.
  always_comb begin
    grant_sel = 1'b0;
    case (req_valid)
      2'b01:   grant_sel = 1'b0;
      2'b10:   grant_sel = 1'b1;
`ifdef ALU_ARB_RR_EN
      2'b11:   grant_sel = ~last_q;
`else
      2'b11:   grant_sel = 1'b0;
`endif
      default: grant_sel = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    f_d       = f_q;
    a_d       = a_q;
    b_d       = b_q;
    shamt_d   = shamt_q;
    y_d       = y_q;
    zero_d    = zero_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready[grant_sel] = 1'b1;
          win_d   = grant_sel;
          last_d  = grant_sel;
          f_d     = grant_sel ? req_f1     : req_f0;
          a_d     = grant_sel ? req_a1     : req_a0;
          b_d     = grant_sel ? req_b1     : req_b0;
          shamt_d = grant_sel ? req_shamt1 : req_shamt0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Illegal codes never expose whatever the ALU produced for them.
        if (is_legal(f_q)) begin
          y_d    = alu_y;
          zero_d = alu_zero;
          err_d  = 1'b0;
        end else begin
          y_d    = '0;
          zero_d = 1'b1;
          err_d  = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[win_q] = 1'b1;
        if (rsp_ready[win_q]) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      f_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      f_q     <= f_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shamt_q <= shamt_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_f     = f_q;
  assign alu_shamt = shamt_q;
  assign rsp_y     = y_q;
  assign rsp_zero  = zero_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model, per-cycle compare, directed vectors.
// Honours ALU_ARB_RR_EN the same way the design does.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 3;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } op_t;

  typedef struct {
    int          port;
    logic [31:0] y;
    logic        zero;
    logic        err;
  } rsp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [3:0]       req_f0 = '0, req_f1 = '0;
  logic [WIDTH-1:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [4:0]       req_shamt0 = '0, req_shamt1 = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero, rsp_err;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [3:0]       alu_f;
  logic [4:0]       alu_shamt;
  logic             alu_zero;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int   checks = 0;
  int   failures = 0;
  op_t  q0[$];
  op_t  q1[$];
  rsp_t log_q[$];
  int   grants[$];
  logic [1:0] rdy_seen = 2'b00;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_f0(req_f0), .req_f1(req_f1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_shamt(alu_shamt),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .busy(busy), .op_count(op_count)
  );

  // Stand-in ALU; illegal codes yield a nonzero pattern the arbiter must suppress.
  function automatic logic [31:0] alu_fn(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] sh);
    case (f)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h4:    return (a + b) << sh;
      4'h5:    return (a + b) >> sh;
      4'hA:    return a - b;
      4'hB:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    alu_y    = alu_fn(alu_f, alu_a, alu_b, alu_shamt);
    alu_zero = (alu_y == 32'd0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) begin
`ifdef ALU_ARB_RR_EN
      return ~last;
`else
      return 1'b0;
`endif
    end
    return v[1];
  endfunction

  int               m_phase;   // 0 idle, 1 computing, 2 awaiting consume
  logic             m_win, m_last;
  op_t              m_op;
  logic [31:0]      m_y;
  logic             m_zero, m_err;
  logic [CNT_W-1:0] m_cnt;

  always @(posedge clk or negedge reset_n) begin : model
    logic w;
    op_t  o;
    if (!reset_n) begin
      m_phase <= 0;
      m_win   <= 1'b0;
      m_last  <= 1'b1;
      m_op    <= '{f: 4'h0, a: 32'h0, b: 32'h0, sh: 5'h0};
      m_y     <= 32'h0;
      m_zero  <= 1'b0;
      m_err   <= 1'b0;
      m_cnt   <= '0;
    end else if (m_phase == 0) begin
      if (req_valid != 2'b00) begin
        w = pick(req_valid, m_last);
        o = w ? '{f: req_f1, a: req_a1, b: req_b1, sh: req_shamt1}
              : '{f: req_f0, a: req_a0, b: req_b0, sh: req_shamt0};
        m_win   <= w;
        m_last  <= w;
        m_op    <= o;
        m_phase <= 1;
        grants.push_back(w ? 1 : 0);
      end
    end else if (m_phase == 1) begin
      if (m_op.f inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'hA, 4'hB}) begin
        m_y    <= alu_fn(m_op.f, m_op.a, m_op.b, m_op.sh);
        m_zero <= (alu_fn(m_op.f, m_op.a, m_op.b, m_op.sh) == 32'd0);
        m_err  <= 1'b0;
      end else begin
        m_y    <= 32'd0;
        m_zero <= 1'b1;
        m_err  <= 1'b1;
      end
      m_phase <= 2;
    end else begin
      if (rsp_ready[m_win]) begin
        m_phase <= 0;
        m_cnt   <= m_cnt + 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [1:0] exp_rdy;
    logic [1:0] exp_vld;
    rsp_t       r;
    exp_rdy = 2'b00;
    if (m_phase == 0 && req_valid != 2'b00)
      exp_rdy = pick(req_valid, m_last) ? 2'b10 : 2'b01;
    exp_vld = (m_phase == 2) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
    check("busy", busy, m_phase != 0);
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, exp_vld);
    check("rsp_y", rsp_y, m_y);
    check("rsp_zero", rsp_zero, m_zero);
    check("rsp_err", rsp_err, m_err);
    check("op_count", op_count, m_cnt);
    check("alu_f", alu_f, m_op.f);
    check("alu_a", alu_a, m_op.a);
    check("alu_b", alu_b, m_op.b);
    check("alu_shamt", alu_shamt, m_op.sh);
    if ((rsp_valid & rsp_ready) != 2'b00) begin
      r.port = rsp_valid[1] ? 1 : 0;
      r.y    = rsp_y;
      r.zero = rsp_zero;
      r.err  = rsp_err;
      log_q.push_back(r);
    end
    rdy_seen = reset_n ? req_ready : 2'b00;
  end

  // ---------------- requester drivers ----------------
  always @(posedge clk) begin : driver
    #1;
    if (rdy_seen[0] && q0.size() != 0) void'(q0.pop_front());
    if (rdy_seen[1] && q1.size() != 0) void'(q1.pop_front());
    rdy_seen = 2'b00;
    req_valid[0] = (q0.size() != 0);
    req_valid[1] = (q1.size() != 0);
    if (q0.size() != 0) begin
      req_f0 = q0[0].f; req_a0 = q0[0].a; req_b0 = q0[0].b; req_shamt0 = q0[0].sh;
    end
    if (q1.size() != 0) begin
      req_f1 = q1[0].f; req_a1 = q1[0].a; req_b1 = q1[0].b; req_shamt1 = q1[0].sh;
    end
  end

  task automatic push(input int port, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh);
    op_t o;
    o = '{f: f, a: a, b: b, sh: sh};
    if (port == 0) q0.push_back(o);
    else           q1.push_back(o);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((q0.size() != 0 || q1.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", n < budget, 1'b1);
  endtask

  task automatic check_last(input string tag, input int port, input logic [31:0] y, input logic zero,
                            input logic err);
    rsp_t r;
    r = log_q[log_q.size()-1];
    check({tag, "_port"}, r.port, port);
    check({tag, "_y"}, r.y, y);
    check({tag, "_zero"}, r.zero, zero);
    check({tag, "_err"}, r.err, err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_op_count"}, op_count, 3'd0);
    check({tag, "_rsp_y"}, rsp_y, 32'd0);
    check({tag, "_rsp_zero"}, rsp_zero, 1'b0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_alu_f"}, alu_f, 4'd0);
    check({tag, "_alu_shamt"}, alu_shamt, 5'd0);
  endtask

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int n;
    int n_log;
    int exp_g[4];
    reset_n   = 1'b1;
    rsp_ready = 2'b11;
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);

    // ADD 5+7 on the EX-stage port
    push(0, 4'h2, 32'd5, 32'd7, 5'd0);
    drain(50);
    check("add_log_size", log_q.size(), 1);
    check_last("add", 0, 32'd12, 1'b0, 1'b0);
    check("add_op_count", op_count, 3'd1);
    check("add_alu_f_held", alu_f, 4'h2);

    push(0, 4'h4, 32'd1, 32'd1, 5'd4);
    drain(50);
    check_last("sll", 0, 32'h20, 1'b0, 1'b0);

    push(0, 4'h3, 32'hFFFF, 32'hFFFF, 5'd0);
    drain(50);
    check_last("illegal", 0, 32'd0, 1'b1, 1'b1);

    push(1, 4'hA, 32'h1234, 32'h1234, 5'd0);
    drain(50);
    check_last("sub", 1, 32'd0, 1'b1, 1'b0);

    // Both requesters valid back to back; last winner was port 1
    grants.delete();
    push(0, 4'h0, 32'hF0F0, 32'hFF00, 5'd0);
    push(0, 4'h1, 32'h0F00, 32'h00F0, 5'd0);
    push(0, 4'h5, 32'h100, 32'h100, 5'd4);
    push(0, 4'hB, 32'hFFFF_FFFF, 32'd1, 5'd0);
    push(1, 4'h2, 32'd100, 32'd23, 5'd0);
    push(1, 4'hA, 32'd10, 32'd3, 5'd0);
    push(1, 4'h4, 32'd2, 32'd2, 5'd3);
    push(1, 4'h0, 32'h1234, 32'h00FF, 5'd0);
    drain(200);
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    check("arb_grant_count", grants.size(), 8);
    for (int i = 0; i < 4; i++) check($sformatf("arb_grant%0d", i), grants[i], exp_g[i]);

    // Backpressure on port 0 while port 1 waits
    rsp_ready = 2'b00;
    push(0, 4'h2, 32'h10, 32'h20, 5'd0);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", rsp_valid[0], 1'b1);
    push(1, 4'h1, 32'h3, 32'h4, 5'd0);
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 2'b01);
      check("bp_rsp_y", rsp_y, 32'h30);
      check("bp_req_ready", req_ready, 2'b00);
      check("bp_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    @(posedge clk);
    #1;
    check("bp_release_idle", busy, 1'b0);
    check("bp_release_rsp_valid", rsp_valid, 2'b00);
    drain(50);
    check_last("bp_follow", 1, 32'h7, 1'b0, 1'b0);

    // Reset while an operation is in EXEC
    n_log = log_q.size();
    push(0, 4'h2, 32'd3, 32'd4, 5'd0);
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_accept_seen", req_ready[0], 1'b1);
    @(posedge clk);
    #1 check("rst_in_exec", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("mid_exec");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dropped", log_q.size(), n_log);
    grants.delete();
    push(0, 4'h2, 32'd1, 32'd1, 5'd0);
    push(1, 4'h2, 32'd2, 32'd2, 5'd0);
    drain(50);
    check("rst_first_grant", grants[0], 0);
    check("rst_log_size", log_q.size(), n_log + 2);
    check("rst_op_count", op_count, 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the single EX-stage `alu` between two requesters: port 0 is the pipeline EX stage, port 1 is the multi-cycle helper (branch compare / address unit).
- Arbitrates, latches the winning operation, and drives the ALU from registers for one cycle.
- Captures `Y`/`zero` and returns the result to the winner over a valid/ready response channel.
- Sits between the requesters and the ALU instance; the ALU stays purely combinational.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width.
- `CNT_W`, default 16: completed-operation counter width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid[1:0]`  in  2: request valid, per requester.
- `req_ready[1:0]`  out  2: request accepted this edge, per requester.
- `req_f0`, `req_f1`  in  4: ALU function code.
- `req_a0`, `req_a1`, `req_b0`, `req_b1`  in  WIDTH: operands.
- `req_shamt0`, `req_shamt1`  in  5: shift amount.
- `rsp_valid[1:0]`  out  2: result valid, routed to the granted requester only.
- `rsp_ready[1:0]`  in  2: result consumed.
- `rsp_y`  out  WIDTH: result.
- `rsp_zero`  out  1: result equals zero.
- `rsp_err`  out  1: illegal function code.
- `alu_a`, `alu_b`  out  WIDTH; `alu_f`  out  4; `alu_shamt`  out  5: to ALU `A`/`B`/`F`/`shamt`.
- `alu_y`  in  WIDTH; `alu_zero`  in  1: from ALU `Y`/`zero`.
- `busy`  out  1: state is not IDLE.
- `op_count`  out  CNT_W: responses completed, wraps.

## Operation
- Legal F codes: 0 AND, 1 OR, 2 ADD, 4 SLL, 5 SRL, A SUB, B SLT. All other codes are illegal.
- SLL and SRL compute (A+B) shifted by `shamt`; the ALU does this and the arbiter passes the operands unchanged.
- FSM states:
  - **IDLE**:
    - `req_ready[i]` = `req_valid[i]` & granted(i), combinational.
    - On accept: latch f/a/b/shamt and winner id, then go to EXEC.
  - **EXEC**:
    - `alu_*` show the latched values.
    - At the edge: legal f captures `rsp_y`=`alu_y`, `rsp_zero`=`alu_zero`, `rsp_err`=0.
    - Illegal f captures `rsp_y`=0, `rsp_zero`=1, `rsp_err`=1.
    - Then go to RESP.
  - **RESP**:
    - `rsp_valid[winner]`=1.
    - When `rsp_ready[winner]`=1: go to IDLE and increment `op_count`.
    - `rsp_ready` of the non-winner is ignored.
- Grant policy: round-robin, see Configuration. Pointer `last` holds the most recent winner and updates only on accept.
- Outside EXEC, `alu_*` hold their last latched values. They are never combinational from `req_*`.
- `rsp_y`/`rsp_zero`/`rsp_err` hold their values until the next EXEC capture.

## Timing
- Reset (async assert, sync-safe release) sets:
  - state IDLE, `last`=1 so requester 0 wins first.
  - `rsp_valid`=0, `rsp_y`=0, `rsp_zero`=0, `rsp_err`=0.
  - `alu_a`=`alu_b`=0, `alu_f`=0, `alu_shamt`=0.
  - `busy`=0, `op_count`=0.
- Latency: accept at edge k, EXEC during cycle k→k+1, `rsp_valid` high from edge k+1.
- Throughput: with `rsp_ready` held high, RESP lasts 1 cycle. The earliest next accept is edge k+3, so one operation per 3 cycles.
- `req_ready` is 0 in EXEC and RESP. Requesters hold `req_*` stable while valid and not ready.
- Backpressure: RESP is held indefinitely with outputs stable.
- Simultaneous `req_valid`=11 in IDLE: the requester ≠ `last` wins; the loser sees `req_ready`=0.
- `op_count` wraps from 2^CNT_W−1 to 0.
- Reset mid-EXEC or mid-RESP: the operation is dropped, no response is issued, and `op_count` is not incremented.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as above.
- Undefined: fixed priority, requester 0 always wins on 11. `last` is still maintained but not used for arbitration.

## Test plan
- Req0 ADD, A=5, B=7, accepted edge k: `alu_f`=2 in EXEC; `rsp_valid[0]` from edge k+1 with `rsp_y`=12, `rsp_zero`=0, `rsp_err`=0; `op_count`=1 after consume.
- Both valid continuously with distinct ops, `rsp_ready` high: grants are 0,1,0,1 under RR. With the macro off, grants are 0,0,0,0 and req1 is never granted.
- Req1 SUB, A=B=0x1234: `rsp_y`=0, `rsp_zero`=1. Req0 SLL, A=1, B=1, shamt=4: `rsp_y`=0x20.
- Req0 F=3, A=B=0xFFFF: `rsp_err`=1, `rsp_y`=0, `rsp_zero`=1.
- Backpressure, `rsp_ready[0]`=0 for 5 cycles: `rsp_valid[0]` stays high, `rsp_y` is stable, `req_ready`=00 and `busy`=1; release gives IDLE on the next edge.
- Assert `reset_n` during EXEC: all outputs at reset values immediately, no `rsp_valid`; after release, the first grant goes to req0.
